// File: rtl/control_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : control_seq_if
// Purpose : Program-memory, datapath-control and data-RAM handshake bundle
//           between the control sequencer (master) and its surroundings.
// Revision: 1.0  initial release
// ============================================================================
interface control_seq_if #(
  parameter int OPC_W  = 5,
  parameter int ADDR_W = 11
);
  localparam int INS_W = OPC_W + ADDR_W;

  logic [INS_W-1:0]  data;
  logic [ADDR_W-1:0] addr;
  logic              acc_zero;
  logic              mem_ready;
  logic [1:0]        sel_a;
  logic              sel_b;
  logic              wr_acc;
  logic              op;
  logic              wr_ram;
  logic              rd_ram;
  logic [ADDR_W-1:0] operand;
  logic              halted;
  logic              illegal;

  modport master (
    input  data, acc_zero, mem_ready,
    output addr, sel_a, sel_b, wr_acc, op, wr_ram, rd_ram, operand, halted, illegal
  );

  modport slave (
    output data, acc_zero, mem_ready,
    input  addr, sel_a, sel_b, wr_acc, op, wr_ram, rd_ram, operand, halted, illegal
  );
endinterface
`default_nettype wire

// File: rtl/control_seq.sv
`default_nettype none
// ============================================================================
// Module  : control_seq
// Purpose : Accumulator-machine control sequencer: fetch/exec/mem/halt FSM,
//           program counter, instruction register and datapath strobes.
// Revision: 1.0  initial release
// ============================================================================
module control_seq #(
  parameter int OPC_W  = 5,
  parameter int ADDR_W = 11
) (
  input  wire logic     clk,
  input  wire logic     reset,
  control_seq_if.master bus
);
  localparam int INS_W = OPC_W + ADDR_W;

  localparam logic [OPC_W-1:0] c_OP_HLT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] c_OP_STO  = OPC_W'(1);
  localparam logic [OPC_W-1:0] c_OP_LD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] c_OP_LDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] c_OP_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] c_OP_ADDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] c_OP_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] c_OP_SUBI = OPC_W'(7);
  localparam logic [OPC_W-1:0] c_OP_JMP  = OPC_W'(8);
  localparam logic [OPC_W-1:0] c_OP_BEQ  = OPC_W'(9);
  localparam logic [OPC_W-1:0] c_OP_BNE  = OPC_W'(10);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [INS_W-1:0]  r_ir;
  logic [ADDR_W-1:0] r_addr;
  logic              r_halted;
  logic              r_illegal;

  logic [OPC_W-1:0]  w_opc;
  logic [ADDR_W-1:0] w_operand;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [1:0]        w_sel_a;
  logic              w_sel_b;
  logic              w_op;
  logic              w_wr_acc;
  logic              w_wr_ram;
  logic              w_rd_ram;

  assign w_opc      = r_ir[INS_W-1:ADDR_W];
  assign w_operand  = r_ir[ADDR_W-1:0];
  assign w_addr_inc = r_addr + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_addr    <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          r_ir    <= bus.data;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          case (w_opc)
            c_OP_LDI, c_OP_ADDI, c_OP_SUBI: begin
              r_addr  <= w_addr_inc;
              r_state <= S_FETCH;
            end
            c_OP_JMP: begin
              r_addr  <= w_operand;
              r_state <= S_FETCH;
            end
            c_OP_BEQ: begin
              r_addr  <= bus.acc_zero ? w_operand : w_addr_inc;
              r_state <= S_FETCH;
            end
            c_OP_BNE: begin
              r_addr  <= bus.acc_zero ? w_addr_inc : w_operand;
              r_state <= S_FETCH;
            end
            c_OP_STO, c_OP_LD, c_OP_ADD, c_OP_SUB: begin
              r_state <= S_MEM;
            end
            c_OP_HLT: begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
            default: begin
              // Undefined opcode stops the core and leaves a sticky flag.
              r_illegal <= 1'b1;
              r_halted  <= 1'b1;
              r_state   <= S_HALT;
            end
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            r_addr  <= w_addr_inc;
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  // Strobes follow state directly so an async reset drops them at once.
  always_comb begin
    w_sel_a  = 2'd0;
    w_sel_b  = 1'b0;
    w_op     = 1'b0;
    w_wr_acc = 1'b0;
    w_wr_ram = 1'b0;
    w_rd_ram = 1'b0;
    if (r_state == S_EXEC) begin
      case (w_opc)
        c_OP_LDI: begin
          w_sel_a  = 2'd1;
          w_wr_acc = 1'b1;
        end
        c_OP_ADDI, c_OP_SUBI: begin
          w_sel_a  = 2'd2;
          w_sel_b  = 1'b1;
          w_op     = (w_opc == c_OP_SUBI);
          w_wr_acc = 1'b1;
        end
        default: ;
      endcase
    end else if (r_state == S_MEM) begin
      case (w_opc)
        c_OP_STO: w_wr_ram = 1'b1;
        c_OP_LD: begin
          w_rd_ram = 1'b1;
          w_wr_acc = bus.mem_ready;
        end
        c_OP_ADD, c_OP_SUB: begin
          w_rd_ram = 1'b1;
          w_sel_a  = 2'd2;
          w_op     = (w_opc == c_OP_SUB);
          w_wr_acc = bus.mem_ready;
        end
        default: ;
      endcase
    end
  end

  assign bus.addr    = r_addr;
  assign bus.operand = w_operand;
  assign bus.halted  = r_halted;
  assign bus.illegal = r_illegal;
  assign bus.sel_a   = w_sel_a;
  assign bus.sel_b   = w_sel_b;
  assign bus.op      = w_op;
  assign bus.wr_acc  = w_wr_acc;
  assign bus.wr_ram  = w_wr_ram;
  assign bus.rd_ram  = w_rd_ram;
endmodule
`default_nettype wire

// File: tb/tb_control_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_seq
// Purpose : Self-checking bench for control_seq, default and wide parameter sets.
// Revision: 1.0  initial release
// ============================================================================
module tb_control_seq;
  localparam logic [4:0] HLT = 5'd0, STO = 5'd1, LD = 5'd2, LDI = 5'd3, ADD = 5'd4;
  localparam logic [4:0] ADDI = 5'd5, SUB = 5'd6, JMP = 5'd8, BEQ = 5'd9, BNE = 5'd10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_seq_if #(.OPC_W(5), .ADDR_W(11)) bus ();
  control_seq_if #(.OPC_W(6), .ADDR_W(14)) bus2 ();

  control_seq #(.OPC_W(5), .ADDR_W(11)) dut  (.clk(clk), .reset(reset), .bus(bus));
  control_seq #(.OPC_W(6), .ADDR_W(14)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [15:0] prog  [0:2047];
  logic [19:0] prog2 [0:16383];
  assign bus.data  = prog[bus.addr];
  assign bus2.data = prog2[bus2.addr];

  wire logic [6:0] st  = {bus.sel_a, bus.sel_b, bus.op, bus.wr_acc, bus.wr_ram, bus.rd_ram};
  wire logic [6:0] st2 = {bus2.sel_a, bus2.sel_b, bus2.op, bus2.wr_acc, bus2.wr_ram, bus2.rd_ram};

  int checks = 0;
  int errors = 0;
  int unsigned cyc_n = 0;

  typedef struct packed {
    int unsigned cyc;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic [10:0] addr;
  } exp_t;
  exp_t sb_q[$];

  // Cycle 1 is the first FETCH after reset release.
  always @(posedge clk) cyc_n <= reset ? cyc_n + 1 : 1;

  // Scoreboard: each accumulator write must match the oldest expected one.
  always @(negedge clk) begin
    exp_t got, want;
    if (reset && bus.wr_acc) begin
      got = {cyc_n, bus.sel_a, bus.sel_b, bus.op, bus.addr};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_wr_acc got cyc=%0d addr=%h exp no write", cyc_n, bus.addr);
      end else begin
        want = sb_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL sb_wr_acc got %h exp %h", got, want);
        end
      end
    end
  end

  function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] a);
    return {o, a};
  endfunction

  function automatic logic [19:0] ins2(input logic [5:0] o, input logic [13:0] a);
    return {o, a};
  endfunction

  function automatic exp_t ev(input int unsigned c, input logic [1:0] sa, input logic sb,
                              input logic o, input logic [10:0] a);
    return {c, sa, sb, o, a};
  endfunction

  task automatic enter_reset;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.acc_zero   = 1'b0;
    bus2.mem_ready = 1'b0;
    bus2.acc_zero  = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 2048; i++) prog[i] = '0;
    for (int i = 0; i < 16384; i++) prog2[i] = '0;
  endtask

  task automatic leave_reset;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_drained(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_left got %0d pending exp 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset;
    enter_reset();
    prog[0]     = ins(LDI, 11'd5);
    prog[1]     = ins(JMP, 11'h123);
    leave_reset();
    sb_q.push_back(ev(2, 2'd1, 1'b0, 1'b0, 11'h000));
    repeat (7) @(negedge clk);
    checks++;
    if ({bus.halted, bus.addr, bus.operand} !== {1'b1, 11'h123, 11'h000}) begin
      errors++;
      $display("FAIL pre_reset_state got %h exp %h", {bus.halted, bus.addr, bus.operand},
               {1'b1, 11'h123, 11'h000});
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({bus.halted, bus.illegal, bus.addr, bus.operand, st} !== '0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", {bus.halted, bus.illegal, bus.addr, bus.operand, st});
    end
    sb_drained("reset");
  endtask

  task automatic test_ldi_addi;
    logic [10:0] ad [1:6] = '{11'd0, 11'd0, 11'd1, 11'd1, 11'd2, 11'd2};
    enter_reset();
    prog[0] = ins(LDI, 11'd5);
    prog[1] = ins(ADDI, 11'd3);
    leave_reset();
    sb_q.push_back(ev(2, 2'd1, 1'b0, 1'b0, 11'd0));
    sb_q.push_back(ev(4, 2'd2, 1'b1, 1'b0, 11'd1));
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.addr !== ad[c]) begin
        errors++;
        $display("FAIL ldi_addi_addr c%0d got %h exp %h", c, bus.addr, ad[c]);
      end
    end
    sb_drained("ldi_addi");
  endtask

  task automatic test_ld_wait;
    int rd_cnt = 0;
    int wr_cnt = 0;
    enter_reset();
    prog[0] = ins(LD, 11'h010);
    leave_reset();
    sb_q.push_back(ev(6, 2'd0, 1'b0, 1'b0, 11'd0));
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) next_cycle();
      bus.mem_ready = (c <= 2) || (c == 6);
      @(negedge clk);
      rd_cnt += int'(bus.rd_ram);
      wr_cnt += int'(bus.wr_ram);
      if (c == 3) begin
        checks++;
        if (bus.operand !== 11'h010) begin
          errors++;
          $display("FAIL ld_operand got %h exp 010", bus.operand);
        end
      end
      if (c == 6 || c == 7) begin
        checks++;
        if (bus.addr !== 11'(c - 6)) begin
          errors++;
          $display("FAIL ld_addr c%0d got %h exp %h", c, bus.addr, 11'(c - 6));
        end
      end
    end
    bus.mem_ready = 1'b0;
    checks++;
    if (rd_cnt != 4 || wr_cnt != 0) begin
      errors++;
      $display("FAIL ld_rd_cycles got rd=%0d wr=%0d exp rd=4 wr=0", rd_cnt, wr_cnt);
    end
    sb_drained("ld_wait");
  endtask

  task automatic test_back_to_back;
    enter_reset();
    prog[0] = ins(ADD, 11'h020);
    prog[1] = ins(SUB, 11'h021);
    prog[2] = ins(STO, 11'h022);
    leave_reset();
    bus.mem_ready = 1'b1;
    sb_q.push_back(ev(3, 2'd2, 1'b0, 1'b0, 11'd0));
    sb_q.push_back(ev(6, 2'd2, 1'b0, 1'b1, 11'd1));
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 8 || c == 9) begin
        checks++;
        if (st !== ((c == 9) ? 7'b0000010 : 7'b0000000)) begin
          errors++;
          $display("FAIL sto_strobes c%0d got %b exp %b", c, st, (c == 9) ? 7'b0000010 : 7'b0);
        end
      end
      if (c == 10) begin
        checks++;
        if (bus.addr !== 11'd3) begin
          errors++;
          $display("FAIL b2b_addr got %h exp 003", bus.addr);
        end
      end
    end
    sb_drained("back_to_back");
  endtask

  task automatic test_branch;
    logic az [1:13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [10:0] ad [1:13] = '{11'h000, 11'h000, 11'h200, 11'h200, 11'h201, 11'h201, 11'h100,
                               11'h100, 11'h101, 11'h101, 11'h7FF, 11'h7FF, 11'h000};
    enter_reset();
    prog[0]      = ins(BEQ, 11'h200);
    prog[11'h200] = ins(BEQ, 11'h300);
    prog[11'h201] = ins(BNE, 11'h100);
    prog[11'h100] = ins(BNE, 11'h050);
    prog[11'h101] = ins(JMP, 11'h7FF);
    prog[11'h7FF] = ins(LDI, 11'd7);
    leave_reset();
    sb_q.push_back(ev(12, 2'd1, 1'b0, 1'b0, 11'h7FF));
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) next_cycle();
      bus.acc_zero = az[c];
      @(negedge clk);
      if (c >= 3 && c[0]) begin
        checks++;
        if (bus.addr !== ad[c]) begin
          errors++;
          $display("FAIL branch_addr c%0d got %h exp %h", c, bus.addr, ad[c]);
        end
      end
    end
    sb_drained("branch");
  endtask

  task automatic test_halt;
    enter_reset();
    for (int i = 0; i < 4; i++) prog[i] = ins(LDI, 11'(i + 1));
    prog[4] = ins(HLT, 11'h3AA);
    leave_reset();
    for (int i = 0; i < 4; i++) sb_q.push_back(ev(2 * i + 2, 2'd1, 1'b0, 1'b0, 11'(i)));
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) next_cycle();
      bus.mem_ready = c[0];
      bus.acc_zero  = ~c[1];
      @(negedge clk);
      if (c == 10) begin
        checks++;
        if (bus.halted !== 1'b0) begin
          errors++;
          $display("FAIL halt_early got %b exp 0", bus.halted);
        end
      end
      if (c > 10) begin
        checks++;
        if ({bus.halted, bus.illegal, bus.addr, st} !== {1'b1, 1'b0, 11'd4, 7'd0}) begin
          errors++;
          $display("FAIL halt_hold c%0d got %h exp %h", c, {bus.halted, bus.illegal, bus.addr, st},
                   {1'b1, 1'b0, 11'd4, 7'd0});
        end
      end
    end
    sb_drained("halt");
  endtask

  task automatic test_illegal;
    enter_reset();
    prog[0] = ins(5'h1F, 11'h000);
    leave_reset();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        checks++;
        if ({bus.illegal, bus.halted, bus.addr, st} !== {(c >= 3), (c >= 3), 11'd0, 7'd0}) begin
          errors++;
          $display("FAIL illegal c%0d got %h exp %h", c, {bus.illegal, bus.halted, bus.addr, st},
                   {(c >= 3), (c >= 3), 11'd0, 7'd0});
        end
      end
    end
  endtask

  task automatic test_sto_reset;
    enter_reset();
    prog[0] = ins(STO, 11'h010);
    prog[1] = ins(LDI, 11'd1);
    leave_reset();
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) next_cycle();
      @(negedge clk);
    end
    checks++;
    if ({bus.wr_ram, bus.addr} !== {1'b1, 11'd0}) begin
      errors++;
      $display("FAIL sto_hold got %h exp %h", {bus.wr_ram, bus.addr}, {1'b1, 11'd0});
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({st, bus.addr, bus.operand} !== '0) begin
      errors++;
      $display("FAIL sto_reset_drop got %h exp 0", {st, bus.addr, bus.operand});
    end
    prog[0] = ins(LDI, 11'd9);
    leave_reset();
    sb_q.push_back(ev(2, 2'd1, 1'b0, 1'b0, 11'd0));
    repeat (3) @(negedge clk);
    checks++;
    if (bus.addr !== 11'd1) begin
      errors++;
      $display("FAIL sto_restart_addr got %h exp 001", bus.addr);
    end
    sb_drained("sto_reset");
  endtask

  task automatic test_param;
    logic [13:0] ad [1:13] = '{14'h0, 14'h0, 14'h1, 14'h1, 14'h2, 14'h2, 14'h2000, 14'h2000,
                               14'h2001, 14'h2001, 14'h3FFF, 14'h3FFF, 14'h0};
    enter_reset();
    prog2[0]       = ins2(6'(LDI), 14'd5);
    prog2[1]       = ins2(6'(ADDI), 14'd3);
    prog2[2]       = ins2(6'(BEQ), 14'h2000);
    prog2[14'h2000] = ins2(6'(BNE), 14'h0010);
    prog2[14'h2001] = ins2(6'(JMP), 14'h3FFF);
    prog2[14'h3FFF] = ins2(6'(LDI), 14'd1);
    bus2.acc_zero = 1'b1;
    leave_reset();
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      checks++;
      if (bus2.addr !== ad[c]) begin
        errors++;
        $display("FAIL wide_addr c%0d got %h exp %h", c, bus2.addr, ad[c]);
      end
      if (c == 2 || c == 12) begin
        checks++;
        if (st2 !== 7'b0100100) begin
          errors++;
          $display("FAIL wide_ldi c%0d got %b exp 0100100", c, st2);
        end
      end
      if (c == 4) begin
        checks++;
        if (st2 !== 7'b1010100) begin
          errors++;
          $display("FAIL wide_addi got %b exp 1010100", st2);
        end
      end
    end
  endtask

  initial begin
    bus.mem_ready  = 1'b0;
    bus.acc_zero   = 1'b0;
    bus2.mem_ready = 1'b0;
    bus2.acc_zero  = 1'b0;
    for (int i = 0; i < 2048; i++) prog[i] = '0;
    for (int i = 0; i < 16384; i++) prog2[i] = '0;
    test_reset();
    test_ldi_addi();
    test_ld_wait();
    test_back_to_back();
    test_branch();
    test_halt();
    test_illegal();
    test_sto_reset();
    test_param();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
